// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared ISA definitions for the decode stage: instruction field bit
// positions, opcode and R-type alu_op encodings, one-hot class bit indices,
// and the decoded-field record carried through the stage.
// -----------------------------------------------------------------------------
package isa_pkg;

    localparam int INSTR_W   = 32;
    localparam int FIELD_W   = 5;
    localparam int TARGET_W  = 27;
    localparam int IMM_SRC_W = 17;
    localparam int NUM_CLS   = 18;

    // Field bit positions within the raw instruction word.
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;
    localparam int RD_MSB     = 26;
    localparam int RD_LSB     = 22;
    localparam int RS_MSB     = 21;
    localparam int RS_LSB     = 17;
    localparam int RT_MSB     = 16;
    localparam int RT_LSB     = 12;
    localparam int SHAMT_MSB  = 11;
    localparam int SHAMT_LSB  = 7;
    localparam int ALU_MSB    = 6;
    localparam int ALU_LSB    = 2;
    localparam int TARGET_MSB = 26;
    localparam int TARGET_LSB = 0;
    localparam int IMM_MSB    = 16;
    localparam int IMM_LSB    = 0;

    // Opcode encodings.
    localparam logic [FIELD_W-1:0] OP_RTYPE = 5'b00000;
    localparam logic [FIELD_W-1:0] OP_J     = 5'b00001;
    localparam logic [FIELD_W-1:0] OP_BNE   = 5'b00010;
    localparam logic [FIELD_W-1:0] OP_JAL   = 5'b00011;
    localparam logic [FIELD_W-1:0] OP_JR    = 5'b00100;
    localparam logic [FIELD_W-1:0] OP_ADDI  = 5'b00101;
    localparam logic [FIELD_W-1:0] OP_BLT   = 5'b00110;
    localparam logic [FIELD_W-1:0] OP_SW    = 5'b00111;
    localparam logic [FIELD_W-1:0] OP_LW    = 5'b01000;
    localparam logic [FIELD_W-1:0] OP_SETX  = 5'b10101;
    localparam logic [FIELD_W-1:0] OP_BEX   = 5'b10110;

    // R-type alu_op encodings.
    localparam logic [FIELD_W-1:0] ALU_ADD = 5'b00000;
    localparam logic [FIELD_W-1:0] ALU_SUB = 5'b00001;
    localparam logic [FIELD_W-1:0] ALU_AND = 5'b00010;
    localparam logic [FIELD_W-1:0] ALU_OR  = 5'b00011;
    localparam logic [FIELD_W-1:0] ALU_SLL = 5'b00100;
    localparam logic [FIELD_W-1:0] ALU_SRA = 5'b00101;
    localparam logic [FIELD_W-1:0] ALU_MUL = 5'b00110;
    localparam logic [FIELD_W-1:0] ALU_DIV = 5'b00111;

    // Bit indices of the one-hot class vector.
    localparam int CLS_ADD  = 0;
    localparam int CLS_ADDI = 1;
    localparam int CLS_SUB  = 2;
    localparam int CLS_AND  = 3;
    localparam int CLS_OR   = 4;
    localparam int CLS_SLL  = 5;
    localparam int CLS_SRA  = 6;
    localparam int CLS_MUL  = 7;
    localparam int CLS_DIV  = 8;
    localparam int CLS_SW   = 9;
    localparam int CLS_LW   = 10;
    localparam int CLS_J    = 11;
    localparam int CLS_BNE  = 12;
    localparam int CLS_BLT  = 13;
    localparam int CLS_JAL  = 14;
    localparam int CLS_JR   = 15;
    localparam int CLS_BEX  = 16;
    localparam int CLS_SETX = 17;

    // Decoded fields held per buffer entry (immediate and tag kept alongside).
    typedef struct packed {
        logic [FIELD_W-1:0]  opcode;
        logic [FIELD_W-1:0]  rd;
        logic [FIELD_W-1:0]  rs;
        logic [FIELD_W-1:0]  rt;
        logic [FIELD_W-1:0]  shamt;
        logic [FIELD_W-1:0]  alu_op;
        logic [TARGET_W-1:0] target;
        logic [NUM_CLS-1:0]  cls;
        logic                illegal;
    } fields_t;

endpackage

// File: rtl/decode_stage_if.sv
// -----------------------------------------------------------------------------
// decode_stage_if
// Handshake bundle of the decode stage: upstream instruction channel, flush,
// and the downstream decoded-record channel.
//   master : upstream/downstream environment (drives in_*, flush, out_ready)
//   slave  : the decode stage itself
// -----------------------------------------------------------------------------
interface decode_stage_if #(
    parameter int DATA_W = 32,
    parameter int SEQ_W  = 8
);
    import isa_pkg::*;

    logic                     flush;
    logic                     in_valid;
    logic [INSTR_W-1:0]       in_instr;
    logic                     in_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [FIELD_W-1:0]       out_opcode;
    logic [FIELD_W-1:0]       out_rd;
    logic [FIELD_W-1:0]       out_rs;
    logic [FIELD_W-1:0]       out_rt;
    logic [FIELD_W-1:0]       out_shamt;
    logic [FIELD_W-1:0]       out_alu_op;
    logic [TARGET_W-1:0]      out_target;
    logic [DATA_W-1:0]        out_imm;
    logic [NUM_CLS-1:0]       out_cls;
    logic                     out_illegal;
    logic [SEQ_W-1:0]         out_seq;

    modport master (
        output flush, in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_opcode, out_rd, out_rs, out_rt,
               out_shamt, out_alu_op, out_target, out_imm, out_cls,
               out_illegal, out_seq
    );

    modport slave (
        input  flush, in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_opcode, out_rd, out_rs, out_rt,
               out_shamt, out_alu_op, out_target, out_imm, out_cls,
               out_illegal, out_seq
    );

endinterface

// File: rtl/instr_field_decode.sv
// -----------------------------------------------------------------------------
// instr_field_decode
// Purely combinational field slicing and class decode of one instruction.
//   instr   : raw 32-bit instruction
//   fields  : sliced fields, one-hot class vector and illegal flag
//   imm_src : raw 17-bit immediate, left to the caller to extend
// -----------------------------------------------------------------------------
module instr_field_decode
    import isa_pkg::*;
(
    input  logic [INSTR_W-1:0]   instr,
    output fields_t              fields,
    output logic [IMM_SRC_W-1:0] imm_src
);

    logic [FIELD_W-1:0] opcode;
    logic [FIELD_W-1:0] alu_op;
    logic [NUM_CLS-1:0] cls;

    assign opcode  = instr[OPCODE_MSB:OPCODE_LSB];
    assign alu_op  = instr[ALU_MSB:ALU_LSB];
    assign imm_src = instr[IMM_MSB:IMM_LSB];

    // NOTE: cls gets a default before the case so every path assigns it;
    // without that an unmatched opcode would infer a latch.
    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: begin
                case (alu_op)
                    ALU_ADD: cls[CLS_ADD] = 1'b1;
                    ALU_SUB: cls[CLS_SUB] = 1'b1;
                    ALU_AND: cls[CLS_AND] = 1'b1;
                    ALU_OR:  cls[CLS_OR]  = 1'b1;
                    ALU_SLL: cls[CLS_SLL] = 1'b1;
                    ALU_SRA: cls[CLS_SRA] = 1'b1;
                    ALU_MUL: cls[CLS_MUL] = 1'b1;
                    ALU_DIV: cls[CLS_DIV] = 1'b1;
                    default: cls = '0;
                endcase
            end
            OP_J:    cls[CLS_J]    = 1'b1;
            OP_BNE:  cls[CLS_BNE]  = 1'b1;
            OP_JAL:  cls[CLS_JAL]  = 1'b1;
            OP_JR:   cls[CLS_JR]   = 1'b1;
            OP_ADDI: cls[CLS_ADDI] = 1'b1;
            OP_BLT:  cls[CLS_BLT]  = 1'b1;
            OP_SW:   cls[CLS_SW]   = 1'b1;
            OP_LW:   cls[CLS_LW]   = 1'b1;
            OP_SETX: cls[CLS_SETX] = 1'b1;
            OP_BEX:  cls[CLS_BEX]  = 1'b1;
            default: cls = '0;
        endcase
    end

    // An empty class vector is exactly the illegal-encoding case.
    always_comb begin
        fields         = '0;
        fields.opcode  = opcode;
        fields.rd      = instr[RD_MSB:RD_LSB];
        fields.rs      = instr[RS_MSB:RS_LSB];
        fields.rt      = instr[RT_MSB:RT_LSB];
        fields.shamt   = instr[SHAMT_MSB:SHAMT_LSB];
        fields.alu_op  = alu_op;
        fields.target  = instr[TARGET_MSB:TARGET_LSB];
        fields.cls     = cls;
        fields.illegal = (cls == '0);
    end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Instruction decode stage with a 2-entry skid buffer. Instructions are
// decoded as they are accepted and the oldest held record is presented
// directly from registers. Each accepted instruction is tagged with a
// wrapping sequence number.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : decode_stage_if.slave (in_* / flush / out_* handshake)
// Parameters: DATA_W (immediate width, >= 17), SEQ_W (tag width),
//             SIGN_IMM (1 = sign-extend, 0 = zero-extend imm[16:0]).
// -----------------------------------------------------------------------------
module decode_stage
    import isa_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int SEQ_W    = 8,
    parameter bit SIGN_IMM = 1'b1
) (
    input  logic          clock,
    input  logic          reset_n,
    decode_stage_if.slave bus
);

    fields_t              new_fields;
    logic [IMM_SRC_W-1:0] imm_src;
    logic [DATA_W-1:0]    new_imm;

    instr_field_decode u_decode (
        .instr   (bus.in_instr),
        .fields  (new_fields),
        .imm_src (imm_src)
    );

    always_comb begin
        if (SIGN_IMM) new_imm = DATA_W'($signed(imm_src));
        else          new_imm = DATA_W'(imm_src);
    end

    // Entry 0 is always the oldest record and is what out_* presents.
    fields_t           slot_fields [2];
    logic [DATA_W-1:0] slot_imm    [2];
    logic [SEQ_W-1:0]  slot_seq    [2];
    logic [1:0]        count;
    logic [1:0]        count_next;
    logic              in_ready_q;
    logic [SEQ_W-1:0]  seq_q;

    logic accept;
    logic drain;
    logic wr0;
    logic wr1;

    // Flush takes priority over both handshakes: nothing enters or leaves.
    assign accept = bus.in_valid && in_ready_q && !bus.flush;
    assign drain  = (count != 2'd0) && bus.out_ready && !bus.flush;

    // A new record lands in entry 0 when it will be the oldest after this
    // edge, otherwise behind the current head in entry 1.
    assign wr0 = accept && ((count == 2'd0) || ((count == 2'd1) && drain));
    assign wr1 = accept && !wr0;

    always_comb begin
        count_next = count;
        if (bus.flush) begin
            count_next = 2'd0;
        end else begin
            case ({accept, drain})
                2'b10:   count_next = count + 2'd1;
                2'b01:   count_next = count - 2'd1;
                default: count_next = count;
            endcase
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; the entry shift depends on that ordering.
    // NOTE: the two buffer entries are reset because the presented record
    // must read as all-zero while reset is held.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count      <= 2'd0;
            in_ready_q <= 1'b0;
            seq_q      <= '0;
            for (int i = 0; i < 2; i++) begin
                slot_fields[i] <= '0;
                slot_imm[i]    <= '0;
                slot_seq[i]    <= '0;
            end
        end else begin
            count      <= count_next;
            in_ready_q <= (count_next != 2'd2);
            if (accept) seq_q <= seq_q + 1'b1;

            if (wr0) begin
                slot_fields[0] <= new_fields;
                slot_imm[0]    <= new_imm;
                slot_seq[0]    <= seq_q;
            end else if (drain) begin
                slot_fields[0] <= slot_fields[1];
                slot_imm[0]    <= slot_imm[1];
                slot_seq[0]    <= slot_seq[1];
            end

            if (wr1) begin
                slot_fields[1] <= new_fields;
                slot_imm[1]    <= new_imm;
                slot_seq[1]    <= seq_q;
            end
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = (count != 2'd0);
    assign bus.out_opcode  = slot_fields[0].opcode;
    assign bus.out_rd      = slot_fields[0].rd;
    assign bus.out_rs      = slot_fields[0].rs;
    assign bus.out_rt      = slot_fields[0].rt;
    assign bus.out_shamt   = slot_fields[0].shamt;
    assign bus.out_alu_op  = slot_fields[0].alu_op;
    assign bus.out_target  = slot_fields[0].target;
    assign bus.out_cls     = slot_fields[0].cls;
    assign bus.out_illegal = slot_fields[0].illegal;
    assign bus.out_imm     = slot_imm[0];
    assign bus.out_seq     = slot_seq[0];

endmodule
